activation_interp_scheduler: RTL

Round-robin scheduler that shares a single piece-wise-linear activation interpolator (16-entry LUT plus linear interpolation, 8-bit signed fixed point) between NREQ requesters, e.g. the LSTM gate units of one layer. It arbitrates requests, splits each input into LUT index and fractional remainder, fetches the base/next LUT entries, interpolates through a 3-stage pipeline, and returns each result tagged with the requester id. The LUT is loaded at run time through a configuration port.

---
 rtl/activation_interp_scheduler_pkg.sv | 11 +
 rtl/activation_interp.sv | 29 ++
 rtl/activation_interp_scheduler.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/activation_interp_scheduler_pkg.sv
// Shared constants and types for the activation interpolator scheduler.
package activation_interp_scheduler_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned IDX_W     = 4;
    localparam int unsigned FRAC_W    = 4;
    localparam int unsigned LUT_DEPTH = 16;

    typedef logic signed [DATA_W-1:0] lut_entry_t;

endpackage

// File: rtl/activation_interp.sv
// Combinational piece-wise-linear interpolation between two LUT entries.
module activation_interp
    import activation_interp_scheduler_pkg::*;
(
    input  lut_entry_t        base,
    input  lut_entry_t        nxt,
    input  logic [FRAC_W-1:0] rem,
    output lut_entry_t        value
);

    logic signed [DATA_W:0]          diff;
    logic signed [DATA_W+FRAC_W+1:0] prod;
    logic signed [DATA_W+FRAC_W+1:0] shifted;
    logic signed [DATA_W+1:0]        sum;
    logic                            unused_bits;

    // Slope times fraction, floor-divided by the segment width, added to the base.
    always_comb begin
        diff    = $signed({nxt[DATA_W-1], nxt}) - $signed({base[DATA_W-1], base});
        prod    = diff * $signed({1'b0, rem});
        shifted = prod >>> FRAC_W;
        sum     = $signed({{2{base[DATA_W-1]}}, base}) + $signed(shifted[DATA_W+1:0]);
        value   = sum[DATA_W-1:0];
    end

    // Upper bits are provably redundant (|slope * rem / 16| < 256); result wraps to 8 bits.
    assign unused_bits = ^{shifted[DATA_W+FRAC_W+1:DATA_W+2], sum[DATA_W+1:DATA_W]};

endmodule

// File: rtl/activation_interp_scheduler.sv
// Round-robin scheduler sharing one LUT interpolator among NREQ requesters.
module activation_interp_scheduler #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic [2:0]               out_id,
    input  logic                     cfg_we,
    input  logic [3:0]               cfg_addr,
    input  logic signed [DATA_W-1:0] cfg_data,
    output logic                     cfg_ready,
    output logic                     busy
);
    import activation_interp_scheduler_pkg::*;

    localparam int unsigned ID_W = 3;

    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   grant_idx;
    logic              grant_any;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   valid_sh;
    int unsigned       cand;
    logic              stall, hs;
    logic [DATA_W-1:0] sel_x;

    lut_entry_t        lut_q [LUT_DEPTH];

    logic              s1_valid;
    logic [DATA_W-1:0] s1_x;
    logic [ID_W-1:0]   s1_id;
    logic [IDX_W-1:0]  s1_idx, s1_idx_nxt;

    logic              s2_valid;
    lut_entry_t        s2_base, s2_nxt;
    logic [FRAC_W-1:0] s2_rem;
    logic [ID_W-1:0]   s2_id;
    lut_entry_t        interp_value;

    // Pick the first valid requester starting from the round-robin pointer.
    always_comb begin
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = 0;
        valid_sh  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand     = (32'(ptr_q) + k) % NREQ;
            valid_sh = req_valid >> cand;
            if (!grant_any && valid_sh[0]) begin
                grant_any = 1'b1;
                grant_idx = ID_W'(cand);
            end
        end
    end

    assign grant     = grant_any ? (NREQ'(1) << grant_idx) : '0;
    assign stall     = out_valid && !out_ready;
    assign req_ready = (rst || stall) ? '0 : grant;
    assign hs        = |req_ready;
    assign sel_x     = DATA_W'(req_data >> (32'(grant_idx) * DATA_W));
    assign busy      = s1_valid || s2_valid || out_valid;
    assign cfg_ready = cfg_we && !busy && !hs && !rst;

    // Highest priority moves to the requester after the one just accepted.
    always_comb begin
        ptr_d = ptr_q;
        if (hs) begin
            ptr_d = (32'(grant_idx) == NREQ - 1) ? '0 : grant_idx + ID_W'(1);
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

    // LUT register file, written only when the pipeline is idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LUT_DEPTH; i++) lut_q[i] <= '0;
        end else if (cfg_ready) begin
            lut_q[cfg_addr] <= cfg_data;
        end
    end

    // Top 4 bits with the sign flipped give an offset-binary segment index; top segment clamps.
    assign s1_idx     = s1_x[DATA_W-1 -: IDX_W] ^ {1'b1, {(IDX_W-1){1'b0}}};
    assign s1_idx_nxt = (s1_idx == IDX_W'(LUT_DEPTH - 1)) ? s1_idx : s1_idx + IDX_W'(1);

    activation_interp u_interp (
        .base  (s2_base),
        .nxt   (s2_nxt),
        .rem   (s2_rem),
        .value (interp_value)
    );

    // Three-stage pipeline; a stall freezes every stage, bubbles included.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_x      <= '0;
            s1_id     <= '0;
            s2_valid  <= 1'b0;
            s2_base   <= '0;
            s2_nxt    <= '0;
            s2_rem    <= '0;
            s2_id     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
        end else if (!stall) begin
            s1_valid  <= hs;
            if (hs) begin
                s1_x  <= sel_x;
                s1_id <= grant_idx;
            end
            s2_valid  <= s1_valid;
            if (s1_valid) begin
                s2_base <= lut_q[s1_idx];
                s2_nxt  <= lut_q[s1_idx_nxt];
                s2_rem  <= s1_x[FRAC_W-1:0];
                s2_id   <= s1_id;
            end
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_data <= interp_value;
                out_id   <= s2_id;
            end
        end
    end

endmodule
